// File: rtl/apb3_cfg_seq_pkg.sv
// Shared types for the APB3 configuration sequencer:
// command op codes, FSM state codes and entry-width helper.
package apb3_cfg_seq_pkg;

    localparam int OP_WTH    = 2;
    localparam int DATA_WTH  = 32;
    localparam int RETRY_WTH = 16;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_WRITE = 2'd1,
        OP_POLL  = 2'd2,
        OP_END   = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_e;

    // Packed command entry is {op, addr, data, mask}.
    function automatic int entry_wth(input int addr_wth);
        return OP_WTH + addr_wth + 2 * DATA_WTH;
    endfunction

endpackage

// File: rtl/apb3_cfg_seq_rom.sv
// Default MAC bring-up command table, combinational on idx_i.
// Ports: idx_i entry index; op_o/addr_o/data_o/mask_o entry fields.
module apb3_cfg_seq_rom
    import apb3_cfg_seq_pkg::*;
#(
    parameter int ADDR_WTH = 10,
    parameter int IDX_WTH  = 4
) (
    input  logic [IDX_WTH-1:0]  idx_i,
    output logic [1:0]          op_o,
    output logic [ADDR_WTH-1:0] addr_o,
    output logic [31:0]         data_o,
    output logic [31:0]         mask_o
);

    localparam int EW = entry_wth(ADDR_WTH);

    logic [EW-1:0] ent;

    function automatic logic [EW-1:0] mk(
        input op_e                 op,
        input logic [ADDR_WTH-1:0] a,
        input logic [31:0]         d,
        input logic [31:0]         m
    );
        return {op, a, d, m};
    endfunction

    // Frame length, MAC address, wait for sw_reset to clear,
    // then enable TX/RX.
    always_comb begin
        ent = mk(OP_END, '0, '0, '0);
        case (32'(idx_i))
            0: ent = mk(OP_WRITE, ADDR_WTH'('h014), 32'h0000_05EE, '0);
            1: ent = mk(OP_WRITE, ADDR_WTH'('h00C), 32'h1122_3344, '0);
            2: ent = mk(OP_WRITE, ADDR_WTH'('h010), 32'h0000_5566, '0);
            3: ent = mk(OP_POLL,  ADDR_WTH'('h008), 32'h0, 32'h2000);
            4: ent = mk(OP_WRITE, ADDR_WTH'('h008), 32'h0000_0003, '0);
            default: ent = mk(OP_END, '0, '0, '0);
        endcase
    end

    assign {op_o, addr_o, data_o, mask_o} = ent;

endmodule

// File: rtl/apb3_cfg_sequencer.sv
// Table-driven APB3 master: walks a command ROM issuing writes/polls.
// Ports: start/busy/done/error/err_idx status, rom_* table, m_apb3_* master.
module apb3_cfg_sequencer
    import apb3_cfg_seq_pkg::*;
#(
    parameter int ADDR_WTH   = 10,
    parameter int IDX_WTH    = 4,
    parameter int POLL_LIMIT = 255
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [IDX_WTH-1:0]  err_idx,
    output logic [IDX_WTH-1:0]  rom_idx,
    input  logic [1:0]          rom_op,
    input  logic [ADDR_WTH-1:0] rom_addr,
    input  logic [31:0]         rom_data,
    input  logic [31:0]         rom_mask,
    output logic [ADDR_WTH-1:0] m_apb3_paddr,
    output logic                m_apb3_psel,
    output logic                m_apb3_penable,
    output logic                m_apb3_pwrite,
    output logic [31:0]         m_apb3_pwdata,
    input  logic                m_apb3_pready,
    input  logic [31:0]         m_apb3_prdata,
    input  logic                m_apb3_pslverror
);

    localparam int EW = entry_wth(ADDR_WTH);
    localparam logic [IDX_WTH-1:0] IDX_LAST = '1;
    localparam logic [RETRY_WTH-1:0] LIMIT = RETRY_WTH'(POLL_LIMIT);

    state_e               state_q, state_d;
    logic [IDX_WTH-1:0]   idx_q, idx_d;
    logic [IDX_WTH-1:0]   err_idx_q, err_idx_d;
    logic [RETRY_WTH-1:0] retry_q, retry_d;
    logic [EW-1:0]        cmd_q, cmd_d;
    logic [31:0]          rdata_q, rdata_d;
    logic psel_q, psel_d, pen_q, pen_d, pwr_q, pwr_d;
    logic busy_q, busy_d, done_q, done_d, err_q, err_d;

    op_e                 op_c, rom_op_c;
    logic [ADDR_WTH-1:0] addr_c;
    logic [31:0]         data_c, mask_c;
    state_e              adv_state;
    logic [IDX_WTH-1:0]  adv_idx;

    assign {op_c, addr_c, data_c, mask_c} = cmd_q;
    assign rom_op_c = op_e'(rom_op);

    // Advance: the last slot acts as an implicit END, never wrapping.
    assign adv_state = (idx_q == IDX_LAST) ? S_DONE : S_FETCH;
    assign adv_idx   = (idx_q == IDX_LAST) ? idx_q : idx_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_idx_d = err_idx_q;
        retry_d   = retry_q;
        cmd_d     = cmd_q;
        rdata_d   = rdata_q;
        pwr_d     = pwr_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d   = S_FETCH;
                    idx_d     = '0;
                    err_idx_d = '0;
                    retry_d   = '0;
                end
            end
            S_FETCH: begin
                cmd_d   = {rom_op, rom_addr, rom_data, rom_mask};
                pwr_d   = (rom_op_c == OP_WRITE);
                retry_d = '0;
                unique case (rom_op_c)
                    OP_WRITE, OP_POLL: state_d = S_SETUP;
                    OP_END:            state_d = S_DONE;
                    default: begin
                        state_d = adv_state;
                        idx_d   = adv_idx;
                    end
                endcase
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
                if (m_apb3_pready) begin
                    if (m_apb3_pslverror) begin
                        state_d   = S_ERR;
                        err_idx_d = idx_q;
                    end else if (op_c == OP_WRITE) begin
                        state_d = adv_state;
                        idx_d   = adv_idx;
                    end else begin
                        rdata_d = m_apb3_prdata;
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (((rdata_q ^ data_c) & mask_c) == '0) begin
                    retry_d = '0;
                    state_d = adv_state;
                    idx_d   = adv_idx;
                end else if (retry_q + 1'b1 == LIMIT) begin
                    state_d   = S_ERR;
                    err_idx_d = idx_q;
                end else begin
                    retry_d = retry_q + 1'b1;
                    state_d = S_SETUP;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Outputs are registered from the next state.
        psel_d = (state_d == S_SETUP) || (state_d == S_ACCESS);
        pen_d  = (state_d == S_ACCESS);
        busy_d = state_d inside {S_FETCH, S_SETUP, S_ACCESS, S_CHECK};
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            err_idx_q <= '0;
            retry_q   <= '0;
            cmd_q     <= '0;
            rdata_q   <= '0;
            pwr_q     <= 1'b0;
            psel_q    <= 1'b0;
            pen_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            err_idx_q <= err_idx_d;
            retry_q   <= retry_d;
            cmd_q     <= cmd_d;
            rdata_q   <= rdata_d;
            pwr_q     <= pwr_d;
            psel_q    <= psel_d;
            pen_q     <= pen_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = err_q;
    assign err_idx        = err_idx_q;
    assign rom_idx        = idx_q;
    assign m_apb3_paddr   = addr_c;
    assign m_apb3_psel    = psel_q;
    assign m_apb3_penable = pen_q;
    assign m_apb3_pwrite  = pwr_q;
    assign m_apb3_pwdata  = data_c;

endmodule

// File: tb/tb_apb3_cfg_sequencer.sv
// Scoreboard bench for apb3_cfg_sequencer with an APB3 slave model.
// Expected transfers are queued by stimulus and checked by the monitor.
module tb_apb3_cfg_sequencer;

    logic        clk = 1'b0;
    logic        rstn, start;
    logic        busy, done, error;
    logic [3:0]  err_idx, rom_idx;
    logic [1:0]  rom_op;
    logic [9:0]  rom_addr;
    logic [31:0] rom_data, rom_mask;
    logic [9:0]  paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic        pready, pslverror;
    logic [31:0] prdata;

    logic [1:0]  r_op;
    logic [9:0]  r_addr;
    logic [31:0] r_data, r_mask;

    logic [1:0]  t_op   [16];
    logic [9:0]  t_addr [16];
    logic [31:0] t_data [16];
    logic [31:0] t_mask [16];
    logic        use_rom;

    typedef struct {
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] data;
    } xfer_t;

    xfer_t       exp_q[$];
    logic [31:0] rd_q[$];
    int          wait_n;
    logic        err_en;
    logic [9:0]  err_addr;
    int          acc_n;
    logic        prev_psel;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    apb3_cfg_sequencer #(
        .ADDR_WTH(10), .IDX_WTH(4), .POLL_LIMIT(5)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .busy(busy), .done(done), .error(error),
        .err_idx(err_idx), .rom_idx(rom_idx),
        .rom_op(rom_op), .rom_addr(rom_addr),
        .rom_data(rom_data), .rom_mask(rom_mask),
        .m_apb3_paddr(paddr), .m_apb3_psel(psel),
        .m_apb3_penable(penable), .m_apb3_pwrite(pwrite),
        .m_apb3_pwdata(pwdata), .m_apb3_pready(pready),
        .m_apb3_prdata(prdata), .m_apb3_pslverror(pslverror)
    );

    apb3_cfg_seq_rom #(.ADDR_WTH(10), .IDX_WTH(4)) u_rom (
        .idx_i(rom_idx), .op_o(r_op), .addr_o(r_addr),
        .data_o(r_data), .mask_o(r_mask)
    );

    always_comb begin
        rom_op   = t_op[rom_idx];
        rom_addr = t_addr[rom_idx];
        rom_data = t_data[rom_idx];
        rom_mask = t_mask[rom_idx];
        if (use_rom) begin
            rom_op   = r_op;
            rom_addr = r_addr;
            rom_data = r_data;
            rom_mask = r_mask;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // APB slave and monitor share one process so ordering is fixed.
    always @(negedge clk) begin
        xfer_t e;
        if (!rstn) begin
            pready    = 1'b0;
            pslverror = 1'b0;
            acc_n     = 0;
            prev_psel = 1'b0;
        end else begin
            if (psel && penable) begin
                acc_n++;
                if (acc_n >= wait_n) begin
                    pready    = 1'b1;
                    pslverror = err_en && (paddr == err_addr);
                    prdata    = 32'h0;
                    if (rd_q.size() > 0) prdata = rd_q.pop_front();
                end else begin
                    pready = 1'b0;
                end
            end else begin
                acc_n     = 0;
                pready    = 1'b0;
                pslverror = 1'b0;
            end
            if (psel && !penable) chk("idle_gap", 32'(prev_psel), 0);
            if (psel && penable && pready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_xfer", 32'(paddr), 32'h3FF);
                end else begin
                    e = exp_q.pop_front();
                    chk("pwrite", 32'(pwrite), 32'(e.wr));
                    chk("paddr", 32'(paddr), 32'(e.addr));
                    if (e.wr) chk("pwdata", pwdata, e.data);
                end
            end
            prev_psel = psel;
        end
    end

    task automatic push(input logic wr, input logic [9:0] a,
                        input logic [31:0] d);
        xfer_t x;
        x.wr = wr;
        x.addr = a;
        x.data = d;
        exp_q.push_back(x);
    endtask

    task automatic fill(input logic [1:0] op);
        for (int i = 0; i < 16; i++) begin
            t_op[i]   = op;
            t_addr[i] = '0;
            t_data[i] = '0;
            t_mask[i] = '0;
        end
    endtask

    task automatic ent(input int i, input logic [1:0] op,
                       input logic [9:0] a, input logic [31:0] d,
                       input logic [31:0] m);
        t_op[i]   = op;
        t_addr[i] = a;
        t_data[i] = d;
        t_mask[i] = m;
    endtask

    task automatic run(input string nm);
        int n;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk({nm, "_busy"}, 32'(busy), 1);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!(done || error) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_tmo"}, 32'(n < 3000), 1);
        chk({nm, "_idle"}, 32'(busy), 0);
        repeat (6) @(negedge clk);
        chk({nm, "_q"}, 32'(exp_q.size()), 0);
    endtask

    initial begin
        int n;
        rstn = 1'b0;
        start = 1'b0;
        use_rom = 1'b0;
        wait_n = 1;
        err_en = 1'b0;
        err_addr = '0;
        fill(2'd3);
        #12;
        chk("rst_out", {psel, penable, busy, done, error, rom_idx, err_idx},
            0);
        @(negedge clk) rstn = 1'b1;

        // Two writes with 2-cycle pready, then END.
        wait_n = 2;
        fill(2'd3);
        ent(0, 2'd1, 10'h008, 32'h0000_0003, 0);
        ent(1, 2'd1, 10'h00C, 32'h1234_5678, 0);
        push(1, 10'h008, 32'h0000_0003);
        push(1, 10'h00C, 32'h1234_5678);
        run("wr2");
        chk("wr2_st", {done, error}, 2'b10);
        chk("wr2_idx", 32'(rom_idx), 2);

        // Poll matches on the fourth read.
        wait_n = 1;
        fill(2'd3);
        ent(0, 2'd2, 10'h0E8, 32'h1, 32'h1);
        rd_q = '{32'h0, 32'h0, 32'h0, 32'h1};
        for (int i = 0; i < 4; i++) push(0, 10'h0E8, 0);
        run("poll");
        chk("poll_st", {done, error}, 2'b10);

        // Poll never matches: five reads, then error at idx 1.
        fill(2'd3);
        ent(0, 2'd1, 10'h020, 32'h0000_00A5, 0);
        ent(1, 2'd2, 10'h0E8, 32'h1, 32'h1);
        push(1, 10'h020, 32'h0000_00A5);
        for (int i = 0; i < 5; i++) push(0, 10'h0E8, 0);
        run("plim");
        chk("plim_st", {done, error}, 2'b01);
        chk("plim_eidx", 32'(err_idx), 1);

        // Slave error on the write at idx 2.
        fill(2'd3);
        for (int i = 0; i < 4; i++)
            ent(i, 2'd1, 10'(32'h010 + 4 * i), 32'(i + 1), 0);
        err_en = 1'b1;
        err_addr = 10'h018;
        for (int i = 0; i < 3; i++)
            push(1, 10'(32'h010 + 4 * i), 32'(i + 1));
        run("serr");
        chk("serr_st", {done, error}, 2'b01);
        chk("serr_eidx", 32'(err_idx), 2);
        err_en = 1'b0;

        // Full table of writes with no END.
        fill(2'd1);
        for (int i = 0; i < 16; i++) begin
            ent(i, 2'd1, 10'(32'h100 + 4 * i), 32'h1000 + 32'(i), 0);
            push(1, 10'(32'h100 + 4 * i), 32'h1000 + 32'(i));
        end
        run("full");
        chk("full_st", {done, error}, 2'b10);
        chk("full_idx", 32'(rom_idx), 15);

        // Reset in the middle of an ACCESS phase.
        fill(2'd3);
        ent(0, 2'd1, 10'h040, 32'h0000_DEAD, 0);
        wait_n = 20;
        push(1, 10'h040, 32'h0000_DEAD);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!(psel && penable) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rmid_acc", 32'(n < 50), 1);
        #2 rstn = 1'b0;
        #1;
        chk("rmid_drop", {psel, penable, busy}, 0);
        exp_q.delete();
        @(negedge clk) rstn = 1'b1;
        repeat (10) @(negedge clk);
        chk("rmid_idle", {psel, busy, done, error}, 0);
        wait_n = 1;
        push(1, 10'h040, 32'h0000_DEAD);
        run("rerun");
        chk("rerun_st", {done, error}, 2'b10);
        chk("rerun_idx", 32'(rom_idx), 1);

        // Default bring-up table from the ROM module.
        use_rom = 1'b1;
        push(1, 10'h014, 32'h0000_05EE);
        push(1, 10'h00C, 32'h1122_3344);
        push(1, 10'h010, 32'h0000_5566);
        push(0, 10'h008, 0);
        push(1, 10'h008, 32'h0000_0003);
        run("rom");
        chk("rom_st", {done, error}, 2'b10);
        chk("rom_idx", 32'(rom_idx), 5);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
